hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/md_busy_timer.sv | 35 +++
 rtl/hazard_scoreboard.sv | 82 ++++++++
 tb/tb_hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared Tnew/Tuse encodings and multiply/divide latency defaults for the hazard scoreboard.
package hazard_scoreboard_pkg;

  // Pipeline timing classes (cycles until produced / needed).
  localparam int unsigned TAlu = 1;
  localparam int unsigned TDm  = 2;
  localparam int unsigned TPc  = 1;
  localparam int unsigned TNw  = 0;

  // Busy cycles loaded into the HI/LO timer when an operation starts.
  localparam int unsigned DefMultLat = 5;
  localparam int unsigned DefDivLat  = 10;

  // Width of the HI/LO busy countdown.
  localparam int unsigned MdCntW = 8;

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO busy countdown: loads a latency on start, counts down to zero.
module md_busy_timer
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MULT_LAT = DefMultLat,
  parameter int unsigned DIV_LAT  = DefDivLat
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [MdCntW-1:0] md_cnt_q, md_cnt_d;

  // A start reloads the timer even if an older operation is still counting.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (start) begin
      md_cnt_d = is_div ? MdCntW'(DIV_LAT) : MdCntW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MdCntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) md_cnt_q <= '0;
    else       md_cnt_q <= md_cnt_d;
  end

  assign busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register Tnew countdown plus HI/LO busy interlock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned MULT_LAT = DefMultLat,
  parameter int unsigned DIV_LAT  = DefDivLat
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_addr_d,
  input  logic [REG_AW-1:0] rt_addr_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic [TNEW_W-1:0] tuse_rs_d,
  input  logic [TNEW_W-1:0] tuse_rt_d,
  input  logic              wr_en_d,
  input  logic [REG_AW-1:0] wr_addr_d,
  input  logic [TNEW_W-1:0] tnew_d,
  input  logic              md_use_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  output logic              stall_pc,
  output logic              stall_d,
  output logic              flush_e,
  output logic              md_busy
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic [TNEW_W-1:0] sb_q [NumRegs];
  logic [TNEW_W-1:0] sb_d [NumRegs];

  logic stall_rs, stall_rt, stall_md, stall, issue;

  // Stall decision uses only registered state, so a same-cycle issue cannot influence it.
  always_comb begin
    stall_rs = valid_d & use_rs_d & (rs_addr_d != '0) & (sb_q[rs_addr_d] > tuse_rs_d);
    stall_rt = valid_d & use_rt_d & (rt_addr_d != '0) & (sb_q[rt_addr_d] > tuse_rt_d);
    stall_md = valid_d & md_use_d & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
    issue    = valid_d & ~stall;
  end

  assign stall_pc = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;

  // Saturating decrement of every entry; an issuing writer reloads its destination instead.
  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - TNEW_W'(1) : '0;
    end
    if (issue && wr_en_d && (wr_addr_d != '0)) begin
      sb_d[wr_addr_d] = tnew_d;
    end
    sb_d[0] = '0;
  end

  // Scoreboard storage; reset wins over load and decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NumRegs; r++) sb_q[r] <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (issue & md_start_d),
    .is_div (md_div_d),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard against a ready-time reference model.
module tb_hazard_scoreboard;

  localparam int MultLat = 5;
  localparam int DivLat  = 10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [1:0] tus;
    logic [1:0] tut;
    logic       wr;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       mu;
    logic       ms;
    logic       mdv;
  } ins_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_d;
  logic [4:0] rs_addr_d, rt_addr_d, wr_addr_d;
  logic       use_rs_d, use_rt_d, wr_en_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       md_use_d, md_start_d, md_div_d;
  logic       stall_pc, stall_d, flush_e, md_busy;

  int tests = 0;
  int fails = 0;

  // Model: cycle at which each register's result becomes forwardable, and HI/LO done cycle.
  int cyc = 0;
  int ready [32];
  int md_done = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .valid_d    (valid_d),
    .rs_addr_d  (rs_addr_d),
    .rt_addr_d  (rt_addr_d),
    .use_rs_d   (use_rs_d),
    .use_rt_d   (use_rt_d),
    .tuse_rs_d  (tuse_rs_d),
    .tuse_rt_d  (tuse_rt_d),
    .wr_en_d    (wr_en_d),
    .wr_addr_d  (wr_addr_d),
    .tnew_d     (tnew_d),
    .md_use_d   (md_use_d),
    .md_start_d (md_start_d),
    .md_div_d   (md_div_d),
    .stall_pc   (stall_pc),
    .stall_d    (stall_d),
    .flush_e    (flush_e),
    .md_busy    (md_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int remaining(input int r);
    if (r == 0) return 0;
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic ins_t mk(input logic [4:0] rs, input logic urs, input logic [1:0] tus,
                              input logic [4:0] rt, input logic urt, input logic [1:0] tut,
                              input logic wr, input logic [4:0] wa, input logic [1:0] tn,
                              input logic mu, input logic ms, input logic mdv);
    ins_t i;
    i.valid = 1'b1; i.rs = rs; i.urs = urs; i.tus = tus; i.rt = rt; i.urt = urt; i.tut = tut;
    i.wr = wr; i.wa = wa; i.tn = tn; i.mu = mu; i.ms = ms; i.mdv = mdv;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '0;
    return i;
  endfunction

  // One cycle: drive, compare against the model, advance the model across the coming edge.
  task automatic drive_cycle(input ins_t ins, input logic rst, output logic dut_stall);
    logic exp_stall, exp_busy;
    reset = rst; valid_d = ins.valid;
    rs_addr_d = ins.rs; use_rs_d = ins.urs; tuse_rs_d = ins.tus;
    rt_addr_d = ins.rt; use_rt_d = ins.urt; tuse_rt_d = ins.tut;
    wr_en_d = ins.wr; wr_addr_d = ins.wa; tnew_d = ins.tn;
    md_use_d = ins.mu; md_start_d = ins.ms; md_div_d = ins.mdv;
    #1;
    exp_busy  = (md_done > cyc);
    exp_stall = ins.valid && ((ins.urs && remaining(int'(ins.rs)) > int'(ins.tus)) ||
                              (ins.urt && remaining(int'(ins.rt)) > int'(ins.tut)) ||
                              (ins.mu && exp_busy));
    check_eq("stall_pc", 32'(stall_pc), 32'(exp_stall));
    check_eq("stall_d",  32'(stall_d),  32'(exp_stall));
    check_eq("flush_e",  32'(flush_e),  32'(exp_stall));
    check_eq("md_busy",  32'(md_busy),  32'(exp_busy));
    dut_stall = stall_pc;
    if (rst) begin
      foreach (ready[r]) ready[r] = 0;
      md_done = 0;
    end else if (ins.valid && !exp_stall) begin
      if (ins.wr && ins.wa != 5'd0) ready[ins.wa] = cyc + 1 + int'(ins.tn);
      if (ins.ms) md_done = cyc + 1 + (ins.mdv ? DivLat : MultLat);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until it issues; returns the number of stall cycles seen.
  task automatic issue_instr(input ins_t ins, output int stalls);
    logic s;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(ins, 1'b0, s);
      if (!s) return;
      stalls++;
    end
    check_eq("issue_timeout", 32'(stalls), 32'd0);
  endtask

  initial begin
    int   n;
    logic s;
    ins_t ri;
    foreach (ready[r]) ready[r] = 0;
    reset = 1'b1;
    valid_d = 1'b0; rs_addr_d = '0; rt_addr_d = '0; wr_addr_d = '0;
    use_rs_d = 1'b0; use_rt_d = 1'b0; wr_en_d = 1'b0;
    tuse_rs_d = '0; tuse_rt_d = '0; tnew_d = '0;
    md_use_d = 1'b0; md_start_d = 1'b0; md_div_d = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state with idle decode.
    drive_cycle(nop(), 1'b0, s);
    check_eq("reset_idle", 32'(s), 32'd0);

    // lw r8 then add r8 (tuse 1): one stall.
    issue_instr(mk(5'd1, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd8, 2'd2, 0, 0, 0), n);
    check_eq("lw_r8_issue", 32'(n), 32'd0);
    issue_instr(mk(5'd8, 1, 2'd1, 5'd2, 1, 2'd1, 1, 5'd10, 2'd1, 0, 0, 0), n);
    check_eq("lw_add_stalls", 32'(n), 32'd1);
    repeat (3) drive_cycle(nop(), 1'b0, s);

    // addu r9 then beq r9: one stall; lw r9 then beq r9: two stalls.
    issue_instr(mk(5'd1, 1, 2'd1, 5'd2, 1, 2'd1, 1, 5'd9, 2'd1, 0, 0, 0), n);
    issue_instr(mk(5'd9, 1, 2'd0, 5'd0, 1, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0), n);
    check_eq("addu_beq_stalls", 32'(n), 32'd1);
    issue_instr(mk(5'd1, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd9, 2'd2, 0, 0, 0), n);
    issue_instr(mk(5'd9, 1, 2'd0, 5'd0, 1, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0), n);
    check_eq("lw_beq_stalls", 32'(n), 32'd2);

    // Writes to r0 never create a hazard.
    issue_instr(mk(5'd1, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd0, 2'd2, 0, 0, 0), n);
    issue_instr(mk(5'd0, 1, 2'd0, 5'd0, 1, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0), n);
    check_eq("r0_no_stall", 32'(n), 32'd0);

    // div then mflo: ten stall cycles.
    issue_instr(mk(5'd3, 1, 2'd1, 5'd4, 1, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1), n);
    check_eq("div_issue", 32'(n), 32'd0);
    issue_instr(mk(5'd0, 0, 2'd0, 5'd0, 0, 2'd0, 1, 5'd11, 2'd1, 1, 0, 0), n);
    check_eq("div_mflo_stalls", 32'(n), 32'd10);

    // mult then mflo: five stall cycles.
    issue_instr(mk(5'd3, 1, 2'd1, 5'd4, 1, 2'd1, 0, 5'd0, 2'd0, 1, 1, 0), n);
    issue_instr(mk(5'd0, 0, 2'd0, 5'd0, 0, 2'd0, 1, 5'd11, 2'd1, 1, 0, 0), n);
    check_eq("mult_mflo_stalls", 32'(n), 32'd5);

    // lw r5, addu r5<-r5 reloads tnew 1, reader with tuse 0 stalls once.
    issue_instr(mk(5'd1, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd5, 2'd2, 0, 0, 0), n);
    issue_instr(mk(5'd5, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd5, 2'd1, 0, 0, 0), n);
    check_eq("lw_addu_r5_stalls", 32'(n), 32'd1);
    issue_instr(mk(5'd5, 1, 2'd0, 5'd0, 0, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0), n);
    check_eq("r5_reload_stalls", 32'(n), 32'd1);

    // rs == rt with differing tuse: the tighter one governs.
    issue_instr(mk(5'd1, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd3, 2'd2, 0, 0, 0), n);
    issue_instr(mk(5'd3, 1, 2'd2, 5'd3, 1, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0), n);
    check_eq("rs_eq_rt_stalls", 32'(n), 32'd2);

    // Reset while sb[r8] = 2 and md_cnt = 7.
    issue_instr(mk(5'd3, 1, 2'd1, 5'd4, 1, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1), n);
    drive_cycle(nop(), 1'b0, s);
    drive_cycle(nop(), 1'b0, s);
    issue_instr(mk(5'd1, 1, 2'd1, 5'd0, 0, 2'd0, 1, 5'd8, 2'd2, 0, 0, 0), n);
    drive_cycle(nop(), 1'b1, s);
    check_eq("md_busy_after_reset", 32'(md_busy), 32'd0);
    issue_instr(mk(5'd8, 1, 2'd0, 5'd8, 1, 2'd0, 0, 5'd0, 2'd0, 1, 0, 0), n);
    check_eq("post_reset_stalls", 32'(n), 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int k = 0; k < 600; k++) begin
      ri.valid = ($urandom_range(0, 9) != 0);
      ri.rs  = 5'($urandom_range(0, 7));
      ri.rt  = 5'($urandom_range(0, 7));
      ri.urs = 1'($urandom_range(0, 1));
      ri.urt = 1'($urandom_range(0, 1));
      ri.tus = 2'($urandom_range(0, 3));
      ri.tut = 2'($urandom_range(0, 3));
      ri.wr  = 1'($urandom_range(0, 1));
      ri.wa  = 5'($urandom_range(0, 7));
      ri.tn  = 2'($urandom_range(0, 3));
      ri.mu  = ($urandom_range(0, 5) == 0);
      ri.ms  = ($urandom_range(0, 7) == 0);
      ri.mdv = 1'($urandom_range(0, 1));
      drive_cycle(ri, ($urandom_range(0, 59) == 0), s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
